// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and per-channel flag state for the clock-divider bank
package clk_div_pkg;

    localparam int NCH_MAX       = 16;
    localparam int DEF_NCH       = 4;
    localparam int DEF_CW        = 8;
    localparam int DEF_INIT_HALF = 0;

    // Counter and half-period registers are CW wide and live beside this struct
    typedef struct packed {
        logic out;
        logic rise;
        logic pend;
        logic halt;
    } chan_state_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// rtl/clk_div_bank_if.sv - config, sync and divided-clock signals of the divider bank
interface clk_div_bank_if
    import clk_div_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int CW  = DEF_CW
);
    localparam int CHW = ch_width(NCH);

    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_half;
    logic           sync_in;
    logic [NCH-1:0] div_out;
    logic [NCH-1:0] rise_pulse;
    logic [NCH-1:0] pending;

    modport master (
        output cfg_valid, cfg_ch, cfg_half, sync_in,
        input  cfg_ready, div_out, rise_pulse, pending
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_half, sync_in,
        output cfg_ready, div_out, rise_pulse, pending
    );

endinterface

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divided-clock channel; CLK_DIV_BANK_GATE_EN adds the en run-enable input
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CW        = DEF_CW,
    parameter int INIT_HALF = DEF_INIT_HALF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          sync,
    input  logic          acc,
    input  logic [CW-1:0] cfg_half,
`ifdef CLK_DIV_BANK_GATE_EN
    input  logic          en,
`endif
    output logic          div_out,
    output logic          rise,
    output logic          pend
);
    localparam logic [CW-1:0] H0 = CW'(INIT_HALF);

    logic [CW-1:0] cnt;
    logic [CW-1:0] h_cur;
    logic [CW-1:0] h_pend;
    chan_state_t   st;
    logic          at_top;
    logic          boundary;
    logic          hold;
    logic          halting;

    assign at_top   = (cnt == h_cur);
    assign boundary = at_top && st.out;

`ifdef CLK_DIV_BANK_GATE_EN
    assign hold    = st.halt && !en;
    assign halting = boundary && !en;
`else
    // halt is never set in this build, so hold stays low
    assign hold    = st.halt;
    assign halting = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            h_cur  <= H0;
            h_pend <= H0;
            st     <= '0;
        end else if (sync) begin
            cnt     <= '0;
            st.out  <= 1'b0;
            st.rise <= 1'b0;
            if (st.pend) begin
                h_cur   <= h_pend;
                st.pend <= 1'b0;
            end
        end else begin
            // acc needs !pend, so it never collides with applying a pending value
            if (acc) begin
                h_pend  <= cfg_half;
                st.pend <= 1'b1;
            end
            if (hold) begin
                st.rise <= 1'b0;
            end else if (at_top) begin
                cnt     <= '0;
                st.out  <= ~st.out;
                st.rise <= ~st.out;
                st.halt <= halting;
                if (boundary && st.pend) begin
                    h_cur   <= h_pend;
                    st.pend <= 1'b0;
                end
            end else begin
                cnt     <= cnt + 1'b1;
                st.rise <= 1'b0;
                st.halt <= 1'b0;
            end
        end
    end

    assign div_out = st.out;
    assign rise    = st.rise;
    assign pend    = st.pend;

endmodule

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - bank of NCH 50% duty clock dividers; CLK_DIV_BANK_GATE_EN adds ch_en
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NCH       = DEF_NCH,
    parameter int CW        = DEF_CW,
    parameter int INIT_HALF = DEF_INIT_HALF
) (
    input  logic           clock,
    input  logic           reset,
`ifdef CLK_DIV_BANK_GATE_EN
    input  logic [NCH-1:0] ch_en,
`endif
    clk_div_bank_if.slave  bus
);
    localparam int CHW = ch_width(NCH);

    logic [NCH-1:0]        div_vec;
    logic [NCH-1:0]        rise_vec;
    logic [NCH-1:0]        pend_vec;
    logic [(1<<CHW)-1:0]   pend_pad;
    logic                  ch_ok;
    logic                  accept;

    // Padding lets a non-power-of-two bank index pend safely with any cfg_ch
    always_comb begin
        pend_pad          = '0;
        pend_pad[NCH-1:0] = pend_vec;
    end

    assign ch_ok         = ({1'b0, bus.cfg_ch} < (CHW+1)'(NCH));
    assign bus.cfg_ready = ch_ok && !pend_pad[bus.cfg_ch] && !bus.sync_in;
    assign accept        = bus.cfg_valid && bus.cfg_ready;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        clk_div_chan #(
            .CW        (CW),
            .INIT_HALF (INIT_HALF)
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .sync     (bus.sync_in),
            .acc      (accept && (bus.cfg_ch == CHW'(i))),
            .cfg_half (bus.cfg_half),
`ifdef CLK_DIV_BANK_GATE_EN
            .en       (ch_en[i]),
`endif
            .div_out  (div_vec[i]),
            .rise     (rise_vec[i]),
            .pend     (pend_vec[i])
        );
    end

    assign bus.div_out    = div_vec;
    assign bus.rise_pulse = rise_vec;
    assign bus.pending    = pend_vec;

endmodule
